// File: rtl/cell_test_pkg.sv
// rtl/cell_test_pkg.sv - shared constants, state encoding and LFSR/MISR helpers for the cell test sequencer
package cell_test_pkg;

  // Register map, selected by wbs_adr_i[3:2]
  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_CFG    = 2'd1;
  localparam logic [1:0] ADR_STATUS = 2'd2;
  localparam logic [1:0] ADR_SIG    = 2'd3;

  // CTRL bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_MODE_BIT  = 1;
  localparam int CTRL_ABORT_BIT = 2;

  // STATUS bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_e;

  // Pattern generator: 16-bit Fibonacci LFSR, taps 16,14,13,11
  localparam logic [15:0] LFSR_SEED = 16'h0001;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Signature register feedback taps: bits 31,21,1,0
  localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] din);
    return {sig[30:0], ^(sig & MISR_TAPS)} ^ din;
  endfunction

endpackage

// File: rtl/cell_test_regs.sv
// rtl/cell_test_regs.sv - Wishbone register file: CTRL strobes, CFG storage, STATUS/SIG readback
module cell_test_regs
  import cell_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        busy_i,
  input  logic        done_i,
  input  logic [15:0] index_i,
  input  logic [31:0] sig_i,
  output logic [7:0]  settle_o,
  output logic [15:0] count_o,
  output logic        start_o,
  output logic        mode_o,
  output logic        abort_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [23:0] cfg_q, cfg_d;
  logic        req;
  logic        wr;
  logic        ctrl_wr;
  logic [1:0]  adr;
  logic [31:0] rdata;

  // Address and data bits outside the decoded fields carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3], wbs_dat_i[31:24]};

  assign adr = wbs_adr_i[3:2];

  // Bus handshake, CFG byte-lane writes, CTRL strobes and readback mux
  always_comb begin
    ack_d   = 1'b0;
    dat_d   = dat_q;
    cfg_d   = cfg_q;
    rdata   = 32'h0;
    req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    wr      = req & wbs_we_i;
    ctrl_wr = wr & (adr == ADR_CTRL) & wbs_sel_i[0];

    unique case (adr)
      ADR_CFG:    rdata = {8'h0, cfg_q};
      ADR_STATUS: begin
        rdata                  = {index_i, 16'h0};
        rdata[STATUS_BUSY_BIT] = busy_i;
        rdata[STATUS_DONE_BIT] = done_i;
      end
      ADR_SIG:    rdata = sig_i;
      default:    rdata = 32'h0;
    endcase

    if (req) begin
      ack_d = 1'b1;
      if (!wbs_we_i) begin
        dat_d = rdata;
      end
    end

    if (wr && adr == ADR_CFG) begin
      for (int b = 0; b < 3; b++) begin
        if (wbs_sel_i[b]) begin
          cfg_d[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
        end
      end
    end
  end

  assign start_o   = ctrl_wr & wbs_dat_i[CTRL_START_BIT];
  assign mode_o    = wbs_dat_i[CTRL_MODE_BIT];
  assign abort_o   = ctrl_wr & wbs_dat_i[CTRL_ABORT_BIT];
  assign settle_o  = cfg_q[7:0];
  assign count_o   = cfg_q[23:8];
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  // Register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
      cfg_q <= 24'h0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      cfg_q <= cfg_d;
    end
  end

endmodule

// File: rtl/cell_test_sequencer.sv
// rtl/cell_test_sequencer.sv - standard-cell test sequencer: pattern FSM, LFSR, response MISR
module cell_test_sequencer
  import cell_test_pkg::*;
#(
  parameter int STIM_W = 16,
  parameter int RESP_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [STIM_W-1:0] stim_o,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy_o
);

  seq_state_e        state_q, state_d;
  logic [STIM_W-1:0] stim_q, stim_d;
  logic [31:0]       sig_q, sig_d;
  logic [15:0]       index_q, index_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              done_q, done_d;
  logic [8:0]        settle_cnt_q, settle_cnt_d;
  logic [15:0]       run_count_q, run_count_d;
  logic [7:0]        run_settle_q, run_settle_d;
  logic              run_mode_q, run_mode_d;
  logic [RESP_W-1:0] resp_s1_q, resp_s2_q;

  logic [7:0]  cfg_settle;
  logic [15:0] cfg_count;
  logic        ctrl_start;
  logic        ctrl_mode;
  logic        ctrl_abort;

  cell_test_regs u_regs (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .busy_i    (busy_o),
    .done_i    (done_q),
    .index_i   (index_q),
    .sig_i     (sig_q),
    .settle_o  (cfg_settle),
    .count_o   (cfg_count),
    .start_o   (ctrl_start),
    .mode_o    (ctrl_mode),
    .abort_o   (ctrl_abort)
  );

  assign busy_o = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign stim_o = stim_q;

  // Next-state logic: run sequencing, pattern generation and signature update
  always_comb begin
    state_d      = state_q;
    stim_d       = stim_q;
    sig_d        = sig_q;
    index_d      = index_q;
    lfsr_d       = lfsr_q;
    done_d       = done_q;
    settle_cnt_d = settle_cnt_q;
    run_count_d  = run_count_q;
    run_settle_d = run_settle_q;
    run_mode_d   = run_mode_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ctrl_start) begin
          sig_d        = 32'h0;
          index_d      = 16'h0;
          done_d       = 1'b0;
          lfsr_d       = LFSR_SEED;
          run_count_d  = cfg_count;
          run_settle_d = cfg_settle;
          run_mode_d   = ctrl_mode;
          if (cfg_count == 16'h0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_APPLY;
            stim_d  = ctrl_mode ? STIM_W'(LFSR_SEED) : '0;
          end
        end
      end
      ST_APPLY: begin
        // Settle window covers the user delay plus the two synchronizer stages
        state_d      = ST_SETTLE;
        settle_cnt_d = {1'b0, run_settle_q} + 9'd1;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 9'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_cnt_d = settle_cnt_q - 9'd1;
        end
      end
      ST_CAPTURE: begin
        sig_d   = misr_step(sig_q, 32'(resp_s2_q));
        index_d = index_q + 16'd1;
        if (run_mode_q) begin
          lfsr_d = lfsr_step(lfsr_q);
        end
        if (index_d == run_count_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_APPLY;
          stim_d  = run_mode_q ? STIM_W'(lfsr_d) : STIM_W'(index_d);
        end
      end
      default: begin
        state_d = ST_IDLE;
        stim_d  = '0;
      end
    endcase

    // Abort wins over everything; partial results stay visible for readback
    if (ctrl_abort) begin
      state_d = ST_IDLE;
      stim_d  = '0;
      done_d  = 1'b0;
      sig_d   = sig_q;
      index_d = index_q;
      lfsr_d  = lfsr_q;
    end
  end

  // Sequencer state registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= ST_IDLE;
      stim_q       <= '0;
      sig_q        <= 32'h0;
      index_q      <= 16'h0;
      lfsr_q       <= LFSR_SEED;
      done_q       <= 1'b0;
      settle_cnt_q <= 9'h0;
      run_count_q  <= 16'h0;
      run_settle_q <= 8'h0;
      run_mode_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      sig_q        <= sig_d;
      index_q      <= index_d;
      lfsr_q       <= lfsr_d;
      done_q       <= done_d;
      settle_cnt_q <= settle_cnt_d;
      run_count_q  <= run_count_d;
      run_settle_q <= run_settle_d;
      run_mode_q   <= run_mode_d;
    end
  end

  // Two-flop synchronizer for the asynchronous cell response
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      resp_s1_q <= '0;
      resp_s2_q <= '0;
    end else begin
      resp_s1_q <= resp_i;
      resp_s2_q <= resp_s1_q;
    end
  end

endmodule

// File: tb/tb_cell_test_sequencer.sv
// tb/tb_cell_test_sequencer.sv - scoreboard bench for cell_test_sequencer
module tb_cell_test_sequencer;

  localparam int STIM_W = 16;
  localparam int RESP_W = 8;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_ni;
  logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [STIM_W-1:0] stim_o;
  logic [RESP_W-1:0] resp_i;
  logic              busy_o;

  cell_test_sequencer #(.STIM_W(STIM_W), .RESP_W(RESP_W)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .stim_o    (stim_o),
    .resp_i    (resp_i),
    .busy_o    (busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct { string name; logic [31:0] val; } rd_exp_t;
  typedef struct { logic [15:0] val; int len; } stim_exp_t;

  rd_exp_t   rd_q[$];
  stim_exp_t stim_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit stim_en = 1'b0;
  bit busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Bus monitor: every read ack pops one expected value
  logic prev_ack = 1'b0;
  always @(posedge wb_clk_i) begin : wb_mon
    rd_exp_t e;
    #2;
    if (wbs_ack_o) begin
      check("ack_single_cycle", {31'h0, prev_ack}, 32'h0);
      if (!wbs_we_i) begin
        if (rd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_read_ack: got %h expected none", wbs_dat_o);
        end else begin
          e = rd_q.pop_front();
          check(e.name, wbs_dat_o, e.val);
        end
      end
    end
    prev_ack = wbs_ack_o;
  end

  // Stimulus monitor: each run of one stim value while busy is compared on its end
  logic [15:0] run_val = 16'h0;
  int          run_len = 0;
  task automatic emit_run();
    stim_exp_t e;
    if (stim_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_stim: got %h for %0d cycles", run_val, run_len);
    end else begin
      e = stim_q.pop_front();
      check("stim_value", {16'h0, run_val}, {16'h0, e.val});
      check("stim_hold_cycles", run_len, e.len);
    end
  endtask

  always @(posedge wb_clk_i) begin
    #2;
    if (busy_o) busy_seen = 1'b1;
    if (stim_en && busy_o) begin
      if (run_len > 0 && stim_o != run_val) begin
        emit_run();
        run_len = 0;
      end
      if (run_len == 0) begin
        run_val = stim_o;
        run_len = 1;
      end else begin
        run_len++;
      end
    end else begin
      if (stim_en && run_len > 0) emit_run();
      run_len = 0;
    end
  end

  task automatic wb_cycle(input logic [1:0] a, input logic we, input logic [31:0] d, input logic [3:0] sel);
    int t;
    @(negedge wb_clk_i);
    wbs_adr_i = {28'h0, a, 2'b00};
    wbs_dat_i = d;
    wbs_sel_i = sel;
    wbs_we_i  = we;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    t = 0;
    do begin
      @(negedge wb_clk_i);
      t++;
    end while (!wbs_ack_o && t < 10);
    if (!wbs_ack_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: got no ack expected ack within 10 cycles");
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel);
    wb_cycle(a, 1'b1, d, sel);
  endtask

  task automatic wb_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.name = name;
    e.val  = exp;
    rd_q.push_back(e);
    wb_cycle(a, 1'b0, 32'h0, 4'hF);
  endtask

  task automatic push_stim(input logic [15:0] v, input int len);
    stim_exp_t e;
    e.val = v;
    e.len = len;
    stim_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy_o && t < 2000) begin
      @(negedge wb_clk_i);
      t++;
    end
    if (busy_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got busy expected idle within 2000 cycles", name);
    end
  endtask

  task automatic wait_stim(input logic [15:0] v, output int at_cyc);
    int t;
    t = 0;
    while (stim_o != v && t < 200) begin
      @(negedge wb_clk_i);
      t++;
    end
    if (stim_o != v) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_stim: got %h expected %h within 200 cycles", stim_o, v);
    end
    at_cyc = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1;
    logic [15:0] v;

    wb_rst_ni = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = 32'h0;
    wbs_dat_i = 32'h0;
    resp_i    = '0;

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    check("rst_stim", {16'h0, stim_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    wb_rst_ni = 1'b1;

    wb_read(2'd0, 32'h0, "rd_ctrl_rst");
    wb_read(2'd1, 32'h0, "rd_cfg_rst");
    wb_read(2'd2, 32'h0, "rd_status_rst");
    wb_read(2'd3, 32'h0, "rd_sig_rst");

    // CFG byte lanes and read-only write
    wb_write(2'd1, 32'h0000_0403, 4'hF);
    wb_read(2'd1, 32'h0000_0403, "rd_cfg_full");
    wb_write(2'd1, 32'hFFFF_FFFF, 4'b0010);
    wb_read(2'd1, 32'h0000_FF03, "rd_cfg_byte1");
    wb_write(2'd1, 32'h0000_0403, 4'hF);
    wb_write(2'd2, 32'hFFFF_FFFF, 4'hF);
    wb_read(2'd2, 32'h0, "rd_status_ro");

    // Counter mode, settle 3, count 4
    stim_en = 1'b1;
    for (int i = 0; i < 4; i++) push_stim(16'(i), 7);
    wb_write(2'd0, 32'h1, 4'h1);
    wait_idle("run_cnt4");
    wb_read(2'd2, 32'h0004_0002, "rd_status_cnt4");
    wb_read(2'd3, 32'h0, "rd_sig_resp0_cnt4");

    // Signature: resp 0 and 8'hA5
    wb_write(2'd1, 32'h0000_0100, 4'hF);
    push_stim(16'h0, 4);
    wb_write(2'd0, 32'h1, 4'h1);
    wait_idle("run_resp0");
    wb_read(2'd3, 32'h0, "rd_sig_resp0");
    resp_i = 8'hA5;
    repeat (3) @(negedge wb_clk_i);
    push_stim(16'h0, 4);
    wb_write(2'd0, 32'h1, 4'h1);
    wait_idle("run_a5");
    wb_read(2'd3, 32'h0000_00A5, "rd_sig_a5");
    wb_write(2'd1, 32'h0000_0200, 4'hF);
    push_stim(16'h0, 4);
    push_stim(16'h1, 4);
    wb_write(2'd0, 32'h1, 4'h1);
    wait_idle("run_a5x2");
    wb_read(2'd3, 32'h0000_01EE, "rd_sig_a5x2");

    // count 0: straight to done
    wb_write(2'd1, 32'h0, 4'hF);
    busy_seen = 1'b0;
    wb_write(2'd0, 32'h1, 4'h1);
    repeat (2) @(negedge wb_clk_i);
    check("cnt0_busy_never", {31'h0, busy_seen}, 32'h0);
    wb_read(2'd2, 32'h0000_0002, "rd_status_cnt0");
    wb_read(2'd3, 32'h0, "rd_sig_cnt0");

    // Abort at pattern 10 with an ignored second start
    stim_en = 1'b0;
    resp_i  = '0;
    wb_write(2'd1, 32'h0000_6400, 4'hF);
    wb_write(2'd0, 32'h1, 4'h1);
    t0 = cyc;
    wait_stim(16'd5, t1);
    wb_write(2'd0, 32'h3, 4'h1);
    wait_stim(16'd10, t1);
    check("abort_pattern10_cycle", t1 - t0, 40);
    wb_write(2'd0, 32'h4, 4'h1);
    check("abort_busy", {31'h0, busy_o}, 32'h0);
    check("abort_stim", {16'h0, stim_o}, 32'h0);
    wb_read(2'd2, 32'h000A_0000, "rd_status_abort");
    wb_read(2'd3, 32'h0, "rd_sig_abort");

    // LFSR mode, count 3; CFG rewritten mid-run
    stim_en = 1'b1;
    wb_write(2'd1, 32'h0000_0300, 4'hF);
    v = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      push_stim(v, 4);
      v = lfsr_model(v);
    end
    wb_write(2'd0, 32'h3, 4'h1);
    wb_write(2'd1, 32'h0000_0100, 4'hF);
    wait_idle("run_lfsr");
    wb_read(2'd2, 32'h0003_0002, "rd_status_lfsr");
    wb_read(2'd1, 32'h0000_0100, "rd_cfg_midrun");

    // Reset during SETTLE
    stim_en = 1'b0;
    wb_write(2'd1, 32'h0000_0305, 4'hF);
    wb_write(2'd0, 32'h3, 4'h1);
    @(posedge wb_clk_i);
    #3;
    check("pre_rst_busy", {31'h0, busy_o}, 32'h1);
    wb_rst_ni = 1'b0;
    #1;
    check("midrst_stim", {16'h0, stim_o}, 32'h0);
    check("midrst_busy", {31'h0, busy_o}, 32'h0);
    check("midrst_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("midrst_dat", wbs_dat_o, 32'h0);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    repeat (20) @(negedge wb_clk_i);
    check("post_rst_busy", {31'h0, busy_o}, 32'h0);
    wb_read(2'd2, 32'h0, "rd_status_postrst");
    wb_read(2'd3, 32'h0, "rd_sig_postrst");
    wb_read(2'd1, 32'h0, "rd_cfg_postrst");

    repeat (3) @(negedge wb_clk_i);
    check("rd_queue_drained", rd_q.size(), 0);
    check("stim_queue_drained", stim_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
